// File: rtl/bldc_ctrl_pkg.sv
// rtl/bldc_ctrl_pkg.sv - shared types and helpers for the BLDC velocity regulator
package bldc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Symmetric clamp to +/-(2^(width-1)-1); callers widen to 64 bits first.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (value > lim) return lim;
    if (value < -lim) return -lim;
    return value;
  endfunction

endpackage

// File: rtl/tick_window_counter.sv
// rtl/tick_window_counter.sv - signed encoder tick count per loop window
module tick_window_counter #(
  parameter int VEL_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    loop_pulse,
  input  logic                    tick,
  input  logic                    tick_up,
  output logic signed [VEL_W-1:0] window_count,
  output logic signed [VEL_W-1:0] measured_velocity
);

  localparam logic signed [VEL_W-1:0] CNT_MAX = VEL_W'((1 << (VEL_W - 1)) - 1);
  localparam logic signed [VEL_W-1:0] ONE     = VEL_W'(1);

  // Count ticks with saturation; on the loop pulse publish the window and
  // start the next one, folding in a tick that lands on the pulse itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_count      <= '0;
      measured_velocity <= '0;
    end else if (loop_pulse) begin
      measured_velocity <= window_count;
      if (tick) window_count <= tick_up ? ONE : -ONE;
      else      window_count <= '0;
    end else if (tick) begin
      if (tick_up && window_count != CNT_MAX)
        window_count <= window_count + ONE;
      else if (!tick_up && window_count != -CNT_MAX)
        window_count <= window_count - ONE;
    end
  end

endmodule

// File: rtl/bldc_velocity_regulator.sv
// rtl/bldc_velocity_regulator.sv - windowed velocity PI with align/run/fault supervisor
module bldc_velocity_regulator
  import bldc_ctrl_pkg::*;
#(
  parameter int                VEL_W       = 16,
  parameter int                GAIN_W      = 12,
  parameter int                ACC_W       = 32,
  parameter int                LOOP_DIV    = 50000,
  parameter int                GAIN_SHIFT  = 8,
  parameter int                RAMP_STEP   = 4,
  parameter int                ALIGN_LOOPS = 200,
  parameter logic [GAIN_W-1:0] ALIGN_GAIN  = 'h3FF,
  parameter int                STALL_LOOPS = 100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     fault_clear,
  input  logic signed [VEL_W-1:0]  desired_velocity,
  input  logic [7:0]               kp,
  input  logic [7:0]               ki,
  input  logic                     encoder_change,
  input  logic                     encoder_direction,
  output logic signed [GAIN_W-1:0] gain,
  output logic                     commutation_enable,
  output logic                     controller_override,
  output logic                     reset_encoder_count,
  output logic signed [VEL_W-1:0]  measured_velocity,
  output state_t                   state,
  output logic                     fault
);

  localparam int LW = (LOOP_DIV > 1) ? $clog2(LOOP_DIV) : 1;
  localparam int CW = 16;
  localparam logic signed [GAIN_W-1:0] GAIN_MAX = GAIN_W'((1 << (GAIN_W - 1)) - 1);

  logic [1:0]               rst_sync;
  logic                     rst_n;
  logic [LW-1:0]            loop_cnt;
  logic                     loop_pulse;
  logic signed [VEL_W-1:0]  window_count;
  logic signed [VEL_W-1:0]  setpoint;
  logic signed [ACC_W-1:0]  acc;
  logic [CW-1:0]            align_cnt;
  logic [CW-1:0]            stall_cnt;
  logic signed [63:0]       diff_w, sp_next_w, err_w, p_w, acc_w, acc_next_w, sum_w;
  logic                     acc_hold;

  // Assert asynchronously, release two clocks later so no flop sees a runt edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Free-running loop timebase, independent of the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          loop_cnt <= '0;
    else if (loop_pulse) loop_cnt <= '0;
    else                 loop_cnt <= loop_cnt + 1'b1;
  end
  assign loop_pulse = (loop_cnt == LW'(LOOP_DIV - 1));

  tick_window_counter #(.VEL_W(VEL_W)) u_window (
    .clk               (clk),
    .rst_n             (rst_n),
    .loop_pulse        (loop_pulse),
    .tick              (encoder_change),
    .tick_up           (encoder_direction),
    .window_count      (window_count),
    .measured_velocity (measured_velocity)
  );

  // Ramp and PI terms, evaluated against the window count being latched this pulse.
  always_comb begin
    diff_w = 64'(desired_velocity) - 64'(setpoint);
    if (diff_w > 64'(RAMP_STEP))       sp_next_w = 64'(setpoint) + 64'(RAMP_STEP);
    else if (diff_w < -64'(RAMP_STEP)) sp_next_w = 64'(setpoint) - 64'(RAMP_STEP);
    else                               sp_next_w = 64'(desired_velocity);
    err_w      = sp_next_w - 64'(window_count);
    p_w        = err_w * $signed({56'd0, kp});
    acc_w      = 64'(acc);
    acc_next_w = sat_signed(acc_w + err_w * $signed({56'd0, ki}), ACC_W);
    sum_w      = sat_signed((p_w + acc_w) >>> GAIN_SHIFT, GAIN_W);
    acc_hold   = (gain == GAIN_MAX && err_w > 64'sd0) ||
                 (gain == -GAIN_MAX && err_w < 64'sd0);
  end

  // Supervisor with registered mode outputs; PI state only moves on RUN pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      gain                <= '0;
      commutation_enable  <= 1'b0;
      controller_override <= 1'b0;
      reset_encoder_count <= 1'b0;
      fault               <= 1'b0;
      setpoint            <= '0;
      acc                 <= '0;
      align_cnt           <= '0;
      stall_cnt           <= '0;
    end else begin
      reset_encoder_count <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state               <= ALIGN;
            align_cnt           <= '0;
            gain                <= ALIGN_GAIN;
            commutation_enable  <= 1'b1;
            controller_override <= 1'b1;
          end
        end
        ALIGN: begin
          if (!enable) begin
            state               <= IDLE;
            gain                <= '0;
            commutation_enable  <= 1'b0;
            controller_override <= 1'b0;
          end else if (loop_pulse) begin
            if (align_cnt == CW'(ALIGN_LOOPS - 1)) begin
              state               <= RUN;
              reset_encoder_count <= 1'b1;
              controller_override <= 1'b0;
              gain                <= '0;
              acc                 <= '0;
              setpoint            <= '0;
              stall_cnt           <= '0;
            end else begin
              align_cnt <= align_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            state              <= IDLE;
            gain               <= '0;
            commutation_enable <= 1'b0;
          end else if (stall_cnt >= CW'(STALL_LOOPS)) begin
            state              <= FAULT;
            fault              <= 1'b1;
            gain               <= '0;
            commutation_enable <= 1'b0;
          end else if (loop_pulse) begin
            setpoint <= VEL_W'(sp_next_w);
            gain     <= GAIN_W'(sum_w);
            if (!acc_hold) acc <= ACC_W'(acc_next_w);
            // Stall judged on the window that has just been published.
            if (setpoint != '0 && measured_velocity == '0) stall_cnt <= stall_cnt + 1'b1;
            else                                          stall_cnt <= '0;
          end
        end
        FAULT: begin
          if (fault_clear) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bldc_velocity_regulator.sv
// tb/tb_bldc_velocity_regulator.sv - directed bench for bldc_velocity_regulator
module tb_bldc_velocity_regulator;

  localparam int VEL_W  = 16;
  localparam int GAIN_W = 12;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     enable = 1'b0;
  logic                     fault_clear = 1'b0;
  logic signed [VEL_W-1:0]  desired_velocity = '0;
  logic [7:0]               kp = 8'd0;
  logic [7:0]               ki = 8'd0;
  logic                     encoder_change = 1'b0;
  logic                     encoder_direction = 1'b0;
  logic signed [GAIN_W-1:0] gain;
  logic                     commutation_enable;
  logic                     controller_override;
  logic                     reset_encoder_count;
  logic signed [VEL_W-1:0]  measured_velocity;
  logic [1:0]               state;
  logic                     fault;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_ramp_gain[5] = '{8, 16, 24, 32, 40};
  int exp_sat_gain[4]  = '{1020, 2047, 2047, 2047};
  int exp_sat_acc[4]   = '{1020, 3060, 3060, 3060};

  always #5 clk = ~clk;

  bldc_velocity_regulator #(
    .VEL_W(VEL_W), .GAIN_W(GAIN_W), .ACC_W(32), .LOOP_DIV(20), .GAIN_SHIFT(0),
    .RAMP_STEP(4), .ALIGN_LOOPS(3), .ALIGN_GAIN(12'h3FF), .STALL_LOOPS(4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .fault_clear         (fault_clear),
    .desired_velocity    (desired_velocity),
    .kp                  (kp),
    .ki                  (ki),
    .encoder_change      (encoder_change),
    .encoder_direction   (encoder_direction),
    .gain                (gain),
    .commutation_enable  (commutation_enable),
    .controller_override (controller_override),
    .reset_encoder_count (reset_encoder_count),
    .measured_velocity   (measured_velocity),
    .state               (state),
    .fault               (fault)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gain"},  32'(gain), 0);
    check_eq({tag, "_state"}, 32'(state), 0);
    check_eq({tag, "_ce"},    32'(commutation_enable), 0);
    check_eq({tag, "_ovr"},   32'(controller_override), 0);
    check_eq({tag, "_rec"},   32'(reset_encoder_count), 0);
    check_eq({tag, "_mv"},    32'(measured_velocity), 0);
    check_eq({tag, "_fault"}, 32'(fault), 0);
  endtask

  // Returns at a negedge whose following posedge is a loop pulse.
  task automatic wait_pulse();
    int n;
    n = 0;
    while (!dut.loop_pulse && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("pulse_timeout", 0, 1);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Window: 7 up, 1 down, then an up strobe on the pulse itself.
    wait_pulse();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      encoder_change    = 1'b1;
      encoder_direction = (i != 3);
      @(negedge clk);
    end
    encoder_change = 1'b0;
    wait_pulse();
    encoder_change    = 1'b1;
    encoder_direction = 1'b1;
    @(negedge clk);
    check_eq("win_mv6", 32'(measured_velocity), 6);
    encoder_direction = 1'b0;
    @(negedge clk);
    @(negedge clk);
    encoder_change = 1'b0;
    wait_pulse();
    @(negedge clk);
    check_eq("win_carry", 32'(measured_velocity), -1);

    // Startup through ALIGN.
    enable = 1'b1;
    @(negedge clk);
    check_eq("align_state", 32'(state), 1);
    check_eq("align_ovr",   32'(controller_override), 1);
    check_eq("align_ce",    32'(commutation_enable), 1);
    check_eq("align_gain",  32'(gain), 1023);
    for (int i = 0; i < 3; i++) begin
      wait_pulse();
      @(negedge clk);
      if (i < 2) begin
        check_eq("align_hold_state", 32'(state), 1);
        check_eq("align_hold_gain",  32'(gain), 1023);
      end else begin
        check_eq("run_state", 32'(state), 2);
        check_eq("run_rec",   32'(reset_encoder_count), 1);
        check_eq("run_ovr",   32'(controller_override), 0);
        check_eq("run_ce",    32'(commutation_enable), 1);
        check_eq("run_gain0", 32'(gain), 0);
      end
    end
    @(negedge clk);
    check_eq("rec_pulse_end", 32'(reset_encoder_count), 0);
    wait_pulse();
    @(negedge clk);
    check_eq("run_first_gain",  32'(gain), 0);
    check_eq("run_first_state", 32'(state), 2);

    // Ramp with P only and no ticks; the stall detector trips right after.
    desired_velocity = 16'sd20;
    kp = 8'd2;
    for (int i = 0; i < 5; i++) begin
      wait_pulse();
      @(negedge clk);
      check_eq($sformatf("ramp_gain%0d", i), 32'(gain), exp_ramp_gain[i]);
    end
    @(negedge clk);
    check_eq("stall_state", 32'(state), 3);
    check_eq("stall_fault", 32'(fault), 1);
    check_eq("stall_gain",  32'(gain), 0);
    check_eq("stall_ce",    32'(commutation_enable), 0);
    @(negedge clk);
    check_eq("fault_ignores_en", 32'(state), 3);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    check_eq("clear_state", 32'(state), 0);
    check_eq("clear_fault", 32'(fault), 0);
    @(negedge clk);
    check_eq("reenable_state", 32'(state), 1);

    // Saturation and anti-windup.
    kp = 8'd255;
    ki = 8'd255;
    desired_velocity = 16'sd127;
    for (int i = 0; i < 3; i++) begin
      wait_pulse();
      @(negedge clk);
    end
    check_eq("sat_run_state", 32'(state), 2);
    for (int i = 0; i < 4; i++) begin
      wait_pulse();
      @(negedge clk);
      check_eq($sformatf("sat_gain%0d", i), 32'(gain), exp_sat_gain[i]);
      check_eq($sformatf("sat_acc%0d", i),  32'(dut.acc), exp_sat_acc[i]);
    end

    // Asynchronous reset mid-RUN.
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check_eq("async_rst_acc", 32'(dut.acc), 0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
